alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Upstream stage of the 8-bit ALU (iiitb_alu).
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the ALU's A/B/op inputs and waits out the ALU's registered latency.
- Captures R and presents it downstream with its opcode tag over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width (matches ALU A/B/R).
- OPW, 3, opcode width (matches ALU op).
- DEPTH, 4, command FIFO depth; power of two, minimum 2.
- ALU_LAT, 1, ALU pipeline depth in clock edges from input sample to R valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  OPW  opcode.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  to ALU A.
- alu_b  out  WIDTH  to ALU B.
- alu_op  out  OPW  to ALU op.
- alu_r  in  WIDTH  from ALU R.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  WIDTH  captured ALU result.
- res_op  out  OPW  opcode that produced res_data.
- busy  out  1  high when state is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; state IDLE.
  - alu_a, alu_b, alu_op, res_data, res_op = 0; res_valid = 0; busy = 0.
  - cmd_ready = 1 after reset.
  - Reset mid-operation discards the in-flight command and all queued commands; no partial result is emitted.
- FIFO:
  - cmd_ready = !full, registered-count based.
  - Push on cmd_valid & cmd_ready.
  - No combinational bypass: a command pushed at edge e is issuable no earlier than edge e+1.
  - Push and pop on the same edge are both honoured; count is unchanged.
  - When full, cmd_ready stays low; a pop at edge e raises cmd_ready after e.
  - Pointers wrap modulo DEPTH; a count of DEPTH+1 entries is unreachable.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, FIFO non-empty: pop head, register it into alu_a/alu_b/alu_op (issue edge), load wait_cnt = ALU_LAT, go to WAIT.
  - IDLE, FIFO empty: stay in IDLE; alu_* hold their last values.
  - WAIT: decrement wait_cnt each edge.
  - WAIT exit: when wait_cnt == 0 at an edge, sample alu_r into res_data and alu_op into res_op, set res_valid = 1, go to HOLD.
  - Net effect: R is sampled at the (ALU_LAT+1)-th edge after the issue edge.
  - HOLD: res_valid, res_data and res_op stay stable until res_ready.
  - HOLD, on res_valid & res_ready with FIFO non-empty: issue the next command on the same edge (back-to-back) and go to WAIT.
  - HOLD, on res_valid & res_ready with FIFO empty: res_valid = 0, go to IDLE.
  - alu_a/alu_b/alu_op must not change during WAIT or HOLD.
- Latency, ALU_LAT=1, idle block, res_ready held high:
  - cmd push at edge e.
  - Issue at e+1.
  - res_valid high after e+3.
  - Sustained throughput: one result per ALU_LAT+2 cycles.
- Ordering: results leave in strict FIFO order; no drops and no duplicates.
- Width: no arithmetic is performed on data; res_data is an exact copy of alu_r. wait_cnt is $clog2(ALU_LAT+1) bits wide.

Optional Feature:
- Macro: ALU_CMD_SEQ_STATS_EN.
- Defined: adds output port done_cnt (16 bits).
  - Reset to 0; increments on every res_valid & res_ready handshake.
  - Wraps 0xFFFF -> 0x0000.
  - Adds output port stall_cnt (16 bits), which increments each cycle in HOLD with res_ready low; saturates at 0xFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - OPW, WIDTH defaults.
  - State enum (IDLE/WAIT/HOLD).
  - Packed command typedef alu_cmd_t {op, a, b}.
- One sub-module: alu_cmd_fifo.
  - Parameterised by entry width and DEPTH.
  - Provides push/pop/full/empty/count.
- The FSM and result register live in the top.

Test Plan:
- Reset, then a single cmd {op=0, a=0x6A, b=0x3B}, res_ready=1 (bench instantiates iiitb_alu):
  - alu_a=0x6A, alu_b=0x3B, alu_op=0 after issue edge.
  - res_valid rises exactly 3 edges after push.
  - res_data equals the ALU R for op 0; res_op=0.
- Burst of 8 cmds, op=0..7, a=0x6A, b=0x3B, res_ready=1:
  - cmd_ready drops after the 4th un-popped push.
  - All 8 results appear in order with res_op = 0,1,...,7.
  - busy falls only after the last handshake.
- Backpressure: res_ready=0 for 10 cycles during HOLD:
  - res_data/res_op stable; alu_* unchanged.
  - FIFO fills to 4 and cmd_ready=0.
  - Raising res_ready drains all 4 back-to-back, each ALU_LAT+2 cycles apart.
- Empty/idle: no cmd_valid for 20 cycles after reset:
  - res_valid=0, busy=0, alu_* stay 0.
- Reset mid-WAIT with 3 cmds queued:
  - rst asserted asynchronously drives res_valid=0, busy=0, cmd_ready=1 immediately.
  - After release, no stale result is emitted.
- With ALU_CMD_SEQ_STATS_EN: 5 handshakes plus 7 stalled HOLD cycles -> done_cnt=5, stall_cnt=7.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Package  : alu_ctrl_pkg
// Brief    : Shared widths, sequencer state encoding and command type for the
//            ALU command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_OPW   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [ALU_OPW-1:0]   op;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
  } alu_cmd_t;

  // Latency counter width; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
// Module   : alu_cmd_fifo
// Brief    : Registered-count synchronous FIFO holding pending ALU commands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_fifo #(
  parameter int  DW    = 14,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign w_push_ok = push_i && !full_o;
  assign w_pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push_ok, w_pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Buffers ALU commands, issues them one at a time, waits out the
//            ALU latency and hands the captured result downstream.
//            Define ALU_CMD_SEQ_STATS_EN to add done_cnt/stall_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int OPW     = ALU_OPW,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [OPW-1:0]   res_op,
`ifdef ALU_CMD_SEQ_STATS_EN
  output logic             busy,
  output logic [15:0]      done_cnt,
  output logic [15:0]      stall_cnt
`else
  output logic             busy
`endif
);

  localparam int CMDW = OPW + 2 * WIDTH;
  localparam int CNTW = cnt_width(ALU_LAT);
  localparam int CW   = $clog2(DEPTH + 1);

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CMDW-1:0] fifo_head;
  logic            w_issue;

  seq_state_t       state_q, state_d;
  logic [CNTW-1:0]  wait_q, wait_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [OPW-1:0]   res_op_q, res_op_d;
  logic             res_valid_q, res_valid_d;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DW    (CMDW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A new command launches from IDLE, or from HOLD on the very edge the
  // current result is accepted, so back-to-back issue costs no extra cycle.
  assign w_issue = !fifo_empty &&
                   ((state_q == IDLE) || ((state_q == HOLD) && res_ready));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_valid_d = res_valid_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: state_d = IDLE;
      WAIT: begin
        if (wait_q == '0) begin
          res_data_d  = alu_r;
          res_op_d    = alu_op_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_issue) begin
      fifo_pop                       = 1'b1;
      {alu_op_d, alu_a_d, alu_b_d}   = fifo_head;
      wait_d                         = CNTW'(ALU_LAT);
      state_d                        = WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

`ifdef ALU_CMD_SEQ_STATS_EN
  logic [15:0] done_cnt_q;
  logic [15:0] stall_cnt_q;

  // done_cnt wraps freely; stall_cnt sticks at its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (res_valid_q && res_ready) done_cnt_q <= done_cnt_q + 16'd1;
      if ((state_q == HOLD) && !res_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign done_cnt  = done_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Self-checking bench for alu_cmd_sequencer with a one-cycle
//            behavioural ALU and an in-order command/result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_r = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [2:0] res_op;
  logic       busy;
`ifdef ALU_CMD_SEQ_STATS_EN
  logic [15:0] done_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int stall_seen = 0;
  bit saw_not_ready = 0;

  logic [18:0] exp_q[$];
  logic [10:0] obs_q[$];
  int          obs_cyc[$];

  alu_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
`ifdef ALU_CMD_SEQ_STATS_EN
    .busy      (busy),
    .done_cnt  (done_cnt),
    .stall_cnt (stall_cnt)
`else
    .busy      (busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a & b);
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Registered ALU stand-in: one edge from operand sample to R.
  always @(posedge clk) alu_r <= alu_f(alu_op, alu_a, alu_b);

  // Inputs only change just after a rising edge, so at the falling edge the
  // handshake that the next rising edge will complete is already decided.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) exp_q.push_back({cmd_op, cmd_a, cmd_b});
      if (res_valid && res_ready) begin
        obs_q.push_back({res_op, res_data});
        obs_cyc.push_back(cyc);
      end
      if (res_valid && !res_ready) stall_seen++;
    end
  end

  task automatic reset_dut();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    stall_seen = 0;
    @(posedge clk); #1;
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output bit ok);
    int t;
    bit acc;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    t = 0; acc = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      if (!cmd_ready) saw_not_ready = 1;
      @(posedge clk); #1;
      t++;
    end
    cmd_valid = 1'b0;
    ok = acc;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    else n_pass++;
    n_checks++;
    if ({res_valid, busy} !== 2'b00)
      $display("FAIL reset_valid_busy: got %b%b expected 00", res_valid, busy);
    else n_pass++;
    n_checks++;
    if ({alu_op, alu_a, alu_b} !== 19'd0)
      $display("FAIL reset_alu: got %h expected 0", {alu_op, alu_a, alu_b});
    else n_pass++;
    n_checks++;
    if ({res_op, res_data} !== 11'd0)
      $display("FAIL reset_res: got %h expected 0", {res_op, res_data});
    else n_pass++;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || {alu_op, alu_a, alu_b} !== 19'd0)
        $display("FAIL idle[%0d]: got valid=%b busy=%b alu=%h expected 0 0 0",
                 i, res_valid, busy, {alu_op, alu_a, alu_b});
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [7:0] r;
    r = alu_f(3'd0, 8'h6A, 8'h3B);
    res_ready = 1'b1;
    cmd_op = 3'd0; cmd_a = 8'h6A; cmd_b = 8'h3B; cmd_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL single_accept: got %b expected 1", cmd_ready);
    else n_pass++;
    @(posedge clk); #1;            // push edge e
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk); // after e+1: issued
    n_checks++;
    if ({alu_op, alu_a, alu_b, res_valid} !== {3'd0, 8'h6A, 8'h3B, 1'b0})
      $display("FAIL single_issue: got op=%h a=%h b=%h v=%b expected 0 6a 3b 0",
               alu_op, alu_a, alu_b, res_valid);
    else n_pass++;
    @(posedge clk); @(negedge clk); // after e+2
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", res_valid);
    else n_pass++;
    @(posedge clk); @(negedge clk); // after e+3
    n_checks++;
    if ({res_valid, res_op, res_data} !== {1'b1, 3'd0, r})
      $display("FAIL single_result: got v=%b op=%h d=%h expected 1 0 %h",
               res_valid, res_op, res_data, r);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if ({res_valid, busy} !== 2'b00)
      $display("FAIL single_done: got v=%b busy=%b expected 0 0", res_valid, busy);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    bit ok, all_ok, early;
    int hs, t;
    logic [10:0] e, g;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    res_ready = 1'b1; saw_not_ready = 0; all_ok = 1;
    for (int i = 0; i < 8; i++) begin
      push_cmd(3'(i), 8'h6A, 8'h3B, ok);
      all_ok &= ok;
    end
    n_checks++;
    if (!all_ok || exp_q.size() != 8)
      $display("FAIL burst_push: got %0d accepted expected 8", exp_q.size());
    else n_pass++;
    n_checks++;
    if (!saw_not_ready) $display("FAIL burst_full: got cmd_ready never low expected low when full");
    else n_pass++;
    hs = obs_q.size(); early = 0; t = 0;
    while (hs < 8 && t < 200) begin
      @(negedge clk);
      if (!busy) early = 1;
      if (res_valid && res_ready) hs++;
      t++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (early || hs != 8 || busy !== 1'b0)
      $display("FAIL burst_busy: got early_drop=%b hs=%0d busy=%b expected 0 8 0", early, hs, busy);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      e = {exp_q[i][18:16], alu_f(exp_q[i][18:16], exp_q[i][15:8], exp_q[i][7:0])};
      g = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      n_checks++;
      if (g !== e || e[10:8] !== 3'(i))
        $display("FAIL burst_order[%0d]: got %h expected %h", i, g, e);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok, all_ok, unstable;
    int t;
    logic [10:0] held_res, e, g;
    logic [18:0] held_alu;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    res_ready = 1'b0;
    push_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), all_ok);
    t = 0;
    while (!res_valid && t < 50) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (res_valid !== 1'b1) $display("FAIL bp_first_valid: got %b expected 1", res_valid);
    else n_pass++;
    held_res = {res_op, res_data};
    held_alu = {alu_op, alu_a, alu_b};
    for (int i = 0; i < 4; i++) begin
      push_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), ok);
      all_ok &= ok;
    end
    n_checks++;
    if (!all_ok || cmd_ready !== 1'b0)
      $display("FAIL bp_fill: got pushes_ok=%b cmd_ready=%b expected 1 0", all_ok, cmd_ready);
    else n_pass++;
    unstable = 0;
    repeat (6) begin
      @(negedge clk);
      if ({res_op, res_data} !== held_res || {alu_op, alu_a, alu_b} !== held_alu ||
          res_valid !== 1'b1 || cmd_ready !== 1'b0)
        unstable = 1;
    end
    @(posedge clk); #1;
    n_checks++;
    if (unstable || {res_op, res_data} !== held_res || {alu_op, alu_a, alu_b} !== held_alu)
      $display("FAIL bp_stable: got res=%h alu=%h expected res=%h alu=%h",
               {res_op, res_data}, {alu_op, alu_a, alu_b}, held_res, held_alu);
    else n_pass++;
    res_ready = 1'b1;
    wait_obs(5, ok);
    n_checks++;
    if (!ok) $display("FAIL bp_drain: got %0d results expected 5", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      e = {exp_q[i][18:16], alu_f(exp_q[i][18:16], exp_q[i][15:8], exp_q[i][7:0])};
      g = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      n_checks++;
      if (g !== e) $display("FAIL bp_order[%0d]: got %h expected %h", i, g, e);
      else n_pass++;
    end
    for (int i = 0; i + 1 < obs_cyc.size(); i++) begin
      n_checks++;
      if (obs_cyc[i+1] - obs_cyc[i] != 3)
        $display("FAIL bp_gap[%0d]: got %0d cycles expected 3", i, obs_cyc[i+1] - obs_cyc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok, all_ok;
    all_ok = 1;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_cmd(3'(i), 8'($urandom), 8'($urandom), ok);
      all_ok &= ok;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;             // one handshake: next command now in flight
    res_ready = 1'b0;
    n_checks++;
    if (!all_ok || busy !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL rstmid_setup: got pushes_ok=%b busy=%b valid=%b expected 1 1 0",
               all_ok, busy, res_valid);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({res_valid, busy, cmd_ready} !== 3'b001)
      $display("FAIL rstmid_async: got valid=%b busy=%b ready=%b expected 0 0 1",
               res_valid, busy, cmd_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b0)
      $display("FAIL rstmid_stale: got %0d results busy=%b expected 0 0", obs_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_random();
    int sent, t;
    bit acc;
    logic [10:0] e, g;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    sent = 0; t = 0; cmd_valid = 1'b0;
    while ((sent < 40 || obs_q.size() < 40) && t < 3000) begin
      if (!cmd_valid && sent < 40 && $urandom_range(0, 9) < 7) begin
        cmd_op = 3'($urandom_range(0, 7));
        cmd_a  = 8'($urandom);
        cmd_b  = 8'($urandom);
        cmd_valid = 1'b1;
      end
      res_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (acc) begin sent++; cmd_valid = 1'b0; end
      t++;
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 40 || obs_q.size() != 40)
      $display("FAIL rand_count: got %0d in %0d out expected 40 40", exp_q.size(), obs_q.size());
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      e = (i < exp_q.size()) ?
          {exp_q[i][18:16], alu_f(exp_q[i][18:16], exp_q[i][15:8], exp_q[i][7:0])} : 11'bx;
      g = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      n_checks++;
      if (g !== e) $display("FAIL rand_order[%0d]: got %h expected %h", i, g, e);
      else n_pass++;
    end
  endtask

`ifdef ALU_CMD_SEQ_STATS_EN
  task automatic test_stats();
    bit ok, all_ok;
    int t;
    reset_dut();
    all_ok = 1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(3'(i), 8'($urandom), 8'($urandom), ok);
      all_ok &= ok;
    end
    t = 0;
    while (stall_seen < 7 && t < 100) begin @(posedge clk); #1; t++; end
    res_ready = 1'b1;
    wait_obs(5, ok);
    @(posedge clk); #1;
    n_checks++;
    if (!all_ok || !ok || done_cnt !== 16'd5)
      $display("FAIL stats_done: got %0d expected 5", done_cnt);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'd7) $display("FAIL stats_stall: got %0d expected 7", stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_burst();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef ALU_CMD_SEQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
